// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data memory port between requester 0 (core LSU) and
// requester 1 (debug/DMA). One access is in flight at a time and each access
// takes a fixed three cycles: IDLE (grant and capture), ACCESS (drive memory),
// RESP (ack pulse to the winner, with registered load data and error flag).
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req*/i_we*/i_func3_*  per-requester request, direction and RV32 size/sign
//   i_addr*/i_wdata*        per-requester byte address and LSB-aligned store data
//   o_ack0/o_ack1           one-cycle completion pulse to the winning requester
//   o_rdata/o_err           load data / rejection flag, valid while an ack is high
//   o_busy                  an access is in progress
//   o_mem_*                 memory port, driven only during ACCESS
//   i_mem_rdata             combinational read data from memory
module dmem_arbiter #(
    parameter logic [15:0] ADDR_LO = 16'h2000,
    parameter logic [15:0] ADDR_HI = 16'h3FFF,
    parameter bit          P0_PRIO = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_req0,
    input  logic        i_we0,
    input  logic [2:0]  i_func3_0,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_wdata0,

    input  logic        i_req1,
    input  logic        i_we1,
    input  logic [2:0]  i_func3_1,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata1,

    output logic        o_ack0,
    output logic        o_ack1,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_busy,

    output logic        o_mem_wren,
    output logic [2:0]  o_mem_func3,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;      // last winner; reset to 1 so requester 0 wins the first tie
    logic        winner_q, winner_d;
    logic        we_q, we_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        any_req;
    logic        grant;
    logic        legal;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            winner_q <= 1'b0;
            we_q     <= 1'b0;
            func3_q  <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            we_q     <= we_d;
            func3_q  <= func3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie either fixed priority
    // to requester 0 or the requester that did not win last time.
    // ------------------------------------------------------------------
    always_comb begin
        any_req = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            grant = P0_PRIO ? 1'b0 : ~last_q;
        end else begin
            grant = i_req1;
        end
    end

    // ------------------------------------------------------------------
    // Legality of the captured request
    // ------------------------------------------------------------------
    logic [1:0]  size_m1;
    logic [16:0] end_addr;
    logic        func_ok;
    logic        lo_ok;
    logic        hi_ok;
    logic        align_ok;

    always_comb begin
        unique case (func3_q)
            3'b000, 3'b100: begin
                func_ok = 1'b1;
                size_m1 = 2'd0;
            end
            3'b001, 3'b101: begin
                func_ok = 1'b1;
                size_m1 = 2'd1;
            end
            3'b010: begin
                func_ok = 1'b1;
                size_m1 = 2'd3;
            end
            default: begin
                func_ok = 1'b0;
                size_m1 = 2'd0;
            end
        endcase

        // 17-bit sum so an access running past 0xFFFF cannot wrap back into range.
        end_addr = {1'b0, addr_q[15:0]} + {15'd0, size_m1};
        lo_ok    = (addr_q[15:0] >= ADDR_LO);
        hi_ok    = (end_addr <= {1'b0, ADDR_HI});

        unique case (size_m1)
            2'd1:    align_ok = ~addr_q[0];
            2'd3:    align_ok = (addr_q[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase

        legal = func_ok & lo_ok & hi_ok & align_ok;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        winner_d = winner_q;
        we_d     = we_q;
        func3_d  = func3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d  = StAccess;
                    winner_d = grant;
                    last_d   = grant;
                    we_d     = grant ? i_we1     : i_we0;
                    func3_d  = grant ? i_func3_1 : i_func3_0;
                    addr_d   = grant ? i_addr1   : i_addr0;
                    wdata_d  = grant ? i_wdata1  : i_wdata0;
                end
            end
            StAccess: begin
                state_d = StResp;
                rdata_d = (legal && !we_q) ? i_mem_rdata : 32'h0;
                err_d   = ~legal;
            end
            StResp: begin
                state_d = StIdle;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_busy      = (state_q != StIdle);
        o_ack0      = (state_q == StResp) & ~winner_q;
        o_ack1      = (state_q == StResp) &  winner_q;
        o_rdata     = rdata_q;
        o_err       = err_q;
        o_mem_wren  = 1'b0;
        o_mem_func3 = 3'b000;
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        if (state_q == StAccess) begin
            // Gated by i_rst_n so the write strobe falls with reset assertion
            // itself, independent of the flop clear-to-output path.
            o_mem_wren  = we_q & legal & i_rst_n;
            o_mem_func3 = func3_q;
            o_mem_addr  = addr_q;
            o_mem_wdata = wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [2:0]  f3_0, f3_1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err, busy, mem_wren;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_LO(16'h2000),
        .ADDR_HI(16'h3FFF),
        .P0_PRIO(1'b0)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req0     (req0),
        .i_we0      (we0),
        .i_func3_0  (f3_0),
        .i_addr0    (addr0),
        .i_wdata0   (wdata0),
        .i_req1     (req1),
        .i_we1      (we1),
        .i_func3_1  (f3_1),
        .i_addr1    (addr1),
        .i_wdata1   (wdata1),
        .o_ack0     (ack0),
        .o_ack1     (ack1),
        .o_rdata    (rdata),
        .o_err      (err),
        .o_busy     (busy),
        .o_mem_wren (mem_wren),
        .o_mem_func3(mem_func3),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Byte-addressed memory model; performs the size/sign handling itself.
    logic [7:0] mem [0:65535];
    logic [15:0] ma;

    always_comb begin
        ma = mem_addr[15:0];
        case (mem_func3)
            3'b000:  mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
            3'b001:  mem_rdata = {{16{mem[ma+16'd1][7]}}, mem[ma+16'd1], mem[ma]};
            3'b010:  mem_rdata = {mem[ma+16'd3], mem[ma+16'd2], mem[ma+16'd1], mem[ma]};
            3'b100:  mem_rdata = {24'h0, mem[ma]};
            3'b101:  mem_rdata = {16'h0, mem[ma+16'd1], mem[ma]};
            default: mem_rdata = 32'h0;
        endcase
    end

    int wren_cnt = 0;
    always @(posedge clk) begin
        if (mem_wren) begin
            wren_cnt = wren_cnt + 1;
            mem[mem_addr[15:0]] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'b00) mem[mem_addr[15:0] + 16'd1] <= mem_wdata[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                mem[mem_addr[15:0] + 16'd2] <= mem_wdata[23:16];
                mem[mem_addr[15:0] + 16'd3] <= mem_wdata[31:24];
            end
        end
    end

    function automatic logic [31:0] peek32(input logic [15:0] a);
        return {mem[a+16'd3], mem[a+16'd2], mem[a+16'd1], mem[a]};
    endfunction

    task automatic poke32(input logic [15:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 16'(i)] = w[8*i +: 8];
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_ack_cyc = -1;
    bit   gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] d, input logic e);
        exp_t x;
        x.id = id;
        x.rdata = d;
        x.err = e;
        sb.push_back(x);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each ack against the next expected response.
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            chk("single_ack", 32'(ack0 & ack1), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("ack_id", ack1 ? 32'd1 : 32'd0, 32'(x.id));
                chk("rdata", rdata, x.rdata);
                chk("err", 32'(err), 32'(x.err));
            end
            if (gap_chk && last_ack_cyc >= 0) chk("ack_spacing", 32'(cyc - last_ack_cyc), 32'd3);
            last_ack_cyc = cyc;
        end
    end

    // ------------------------------------------------------------------
    // Requester driver: hold the request until nacks acks, drop in ack cycle.
    // ------------------------------------------------------------------
    task automatic set_req(input int id, input logic r, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d);
        if (id == 0) begin
            req0 = r; we0 = w; f3_0 = f; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; f3_1 = f; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_req(input int id, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d, input int nacks);
        int got = 0;
        int waited = 0;
        set_req(id, 1'b1, w, f, a, d);
        while (got < nacks && waited < 60) begin
            @(negedge clk);
            waited++;
            if ((id == 0 && ack0) || (id == 1 && ack1)) got++;
        end
        set_req(id, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        if (got < nacks) chk("req_timeout", 32'(got), 32'(nacks));
    endtask

    initial begin
        int w0;
        int waited;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        poke32(16'h2100, 32'h0123_4567);
        poke32(16'h2200, 32'h89AB_CDEF);
        poke32(16'h2300, 32'h1122_3344);
        poke32(16'h3FFC, 32'hA5A5_5A5A);
        mem[16'h2004] = 8'h80;

        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'({ack0, ack1}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // Test 2: both loads held from reset, round-robin 0,1,0,1 spaced by 3 cycles
        push(0, 32'h0123_4567, 1'b0);
        push(1, 32'h89AB_CDEF, 1'b0);
        push(0, 32'h0123_4567, 1'b0);
        push(1, 32'h89AB_CDEF, 1'b0);
        gap_chk = 1'b1;
        fork
            do_req(0, 1'b0, 3'b010, 32'h2100, 32'h0, 2);
            do_req(1, 1'b0, 3'b010, 32'h2200, 32'h0, 2);
            begin
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        gap_chk = 1'b0;
        @(negedge clk);

        // Test 1: store then load back
        w0 = wren_cnt;
        push(0, 32'h0, 1'b0);
        do_req(0, 1'b1, 3'b010, 32'h2000, 32'hDEAD_BEEF, 1);
        chk("sw_wren_cycles", 32'(wren_cnt - w0), 32'd1);
        push(0, 32'hDEAD_BEEF, 1'b0);
        do_req(0, 1'b0, 3'b010, 32'h2000, 32'h0, 1);

        // Test 3: word crossing ADDR_HI
        w0 = wren_cnt;
        push(1, 32'h0, 1'b1);
        do_req(1, 1'b0, 3'b010, 32'h3FFE, 32'h0, 1);
        // Test 4: misaligned half and illegal func3 store
        push(0, 32'h0, 1'b1);
        do_req(0, 1'b0, 3'b001, 32'h2001, 32'h0, 1);
        push(0, 32'h0, 1'b1);
        do_req(0, 1'b1, 3'b011, 32'h2000, 32'h1234_5678, 1);
        // Below ADDR_LO, and an illegal store below range
        push(1, 32'h0, 1'b1);
        do_req(1, 1'b0, 3'b000, 32'h1FFF, 32'h0, 1);
        push(1, 32'h0, 1'b1);
        do_req(1, 1'b1, 3'b010, 32'h1FFC, 32'h5555_5555, 1);
        chk("illegal_no_wren", 32'(wren_cnt - w0), 32'd0);
        chk("illegal_mem_intact", peek32(16'h2000), 32'hDEAD_BEEF);

        // Test 5/6: sign and zero extension; highest legal word and half
        push(0, 32'hFFFF_FF80, 1'b0);
        do_req(0, 1'b0, 3'b000, 32'h2004, 32'h0, 1);
        push(0, 32'h0000_0080, 1'b0);
        do_req(0, 1'b0, 3'b100, 32'h2004, 32'h0, 1);
        push(1, 32'hA5A5_5A5A, 1'b0);
        do_req(1, 1'b0, 3'b010, 32'h3FFC, 32'h0, 1);
        push(1, 32'h0000_A5A5, 1'b0);
        do_req(1, 1'b0, 3'b101, 32'h3FFE, 32'h0, 1);

        // Test 7: reset during ACCESS of a store
        set_req(0, 1'b1, 1'b1, 3'b010, 32'h2300, 32'hCAFE_F00D);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_wren && waited < 10);
        chk("abort_saw_wren", 32'(mem_wren), 32'd1);
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("abort_wren_low", 32'(mem_wren), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_mem_intact", peek32(16'h2300), 32'h1122_3344);
        chk("post_abort_busy", 32'(busy), 32'd0);

        // Test 8: tie after reset goes to requester 0
        push(0, 32'h0123_4567, 1'b0);
        push(1, 32'h89AB_CDEF, 1'b0);
        fork
            do_req(0, 1'b0, 3'b010, 32'h2100, 32'h0, 1);
            do_req(1, 1'b0, 3'b010, 32'h2200, 32'h0, 1);
        join

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
